// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide, synchronous-read data RAM.
// Handles one RV32I load/store at a time. Sub-word stores are done as
// read-modify-write. Illegal, misaligned and out-of-range requests are
// answered without any memory access.
module dmem_lsu #(
   parameter int unsigned RAM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic        busy,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_we,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_ADDR = 3'd1,
      LD_DATA = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_WR  = 3'd5
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE = 2'b10;
   localparam logic [1:0] ERR_ILL   = 2'b11;

   state_t      state;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] data_in_q;
   logic        illegal;
   logic        misaligned;
   logic        out_of_range;
   logic [1:0]  err_code;

   // Select the addressed byte/halfword and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'd0:    r = {{24{b[7]}}, b};
         3'd1:    r = {{16{h[15]}}, h};
         3'd4:    r = {24'd0, b};
         3'd5:    r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the target byte/halfword lane of the read word with store data.
   function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word,
                                               input logic [31:0] wdata);
      logic [31:0] r;
      r = word;
      if (f3 == 3'd0) begin
         r[8*lane +: 8] = wdata[7:0];
      end else if (lane[1]) begin
         r[31:16] = wdata[15:0];
      end else begin
         r[15:0] = wdata[15:0];
      end
      return r;
   endfunction

   // Request classification with priority illegal > misaligned > out of range.
   always_comb begin
      illegal      = req_we ? (req_funct3 >= 3'd3)
                            : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
      misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
      out_of_range = (req_addr >= 32'(RAM_BYTES));
      err_code     = ERR_OK;
      if (illegal) begin
         err_code = ERR_ILL;
      end else if (misaligned) begin
         err_code = ERR_ALIGN;
      end else if (out_of_range) begin
         err_code = ERR_RANGE;
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // The RAM's read word only arrives in the RMW_WR cycle, so the merged
   // word is driven straight through during that single write cycle; every
   // other cycle presents the registered write word.
   assign mem_data_in = (state == RMW_WR)
                        ? store_merge(funct3_q, lane_q, mem_data_out, wdata_q)
                        : data_in_q;

   // Control FSM with registered memory-side and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= ERR_OK;
         mem_address <= '0;
         data_in_q   <= '0;
         mem_we      <= 1'b0;
         funct3_q    <= '0;
         lane_q      <= '0;
         wdata_q     <= '0;
      end else begin
         resp_valid <= 1'b0;
         mem_we     <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (err_code != ERR_OK) begin
                     resp_valid <= 1'b1;
                     resp_err   <= err_code;
                     resp_rdata <= '0;
                  end else begin
                     funct3_q    <= req_funct3;
                     lane_q      <= req_addr[1:0];
                     wdata_q     <= req_wdata;
                     mem_address <= {req_addr[31:2], 2'b00};
                     if (!req_we) begin
                        state <= LD_ADDR;
                     end else if (req_funct3 == 3'd2) begin
                        state     <= ST_WR;
                        mem_we    <= 1'b1;
                        data_in_q <= req_wdata;
                     end else begin
                        state <= RMW_RD;
                     end
                  end
               end
            end
            LD_ADDR: state <= LD_DATA;
            LD_DATA: begin
               resp_valid <= 1'b1;
               resp_err   <= ERR_OK;
               resp_rdata <= load_extend(funct3_q, lane_q, mem_data_out);
               state      <= IDLE;
            end
            ST_WR: begin
               resp_valid <= 1'b1;
               resp_err   <= ERR_OK;
               resp_rdata <= '0;
               state      <= IDLE;
            end
            RMW_RD: begin
               mem_we <= 1'b1;
               state  <= RMW_WR;
            end
            RMW_WR: begin
               data_in_q  <= store_merge(funct3_q, lane_q, mem_data_out, wdata_q);
               resp_valid <= 1'b1;
               resp_err   <= ERR_OK;
               resp_rdata <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural synchronous-read RAM, scoreboard queue of
// expected responses filled by the driver and drained by a response monitor.
module tb_dmem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        busy;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_we;
   logic [31:0] mem_data_out;

   dmem_lsu #(.RAM_BYTES(2048)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .busy(busy), .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_we(mem_we), .mem_data_out(mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
      int          acc;
      int          id;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          we_cycles = 0;
   logic [31:0] last_we_addr = '0;
   logic [31:0] ram [0:511];

   // Word RAM: write and read both registered on the rising edge.
   always @(posedge clk) begin
      if (mem_we) ram[mem_address[10:2]] <= mem_data_in;
      mem_data_out <= ram[mem_address[10:2]];
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Track write-enable cycles and the address of the most recent write.
   always @(negedge clk) begin
      if (mem_we) begin
         we_cycles    = we_cycles + 1;
         last_we_addr = mem_address;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every resp_valid pulse must match the queue head.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         checks = checks + 1;
         if (sb_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_resp: rdata %h err %0d at cycle %0d, none expected",
                     resp_rdata, resp_err, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err || cyc != e.acc + e.lat - 1) begin
               errors = errors + 1;
               $display("FAIL resp_op%0d: got rdata %h err %0d latency %0d, expected rdata %h err %0d latency %0d",
                        e.id, resp_rdata, resp_err, cyc - e.acc + 1, e.rdata, e.err, e.lat);
            end
         end
      end
   end

   int op_id = 0;

   // Present a request (called at a falling edge) and hold it until accepted.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] erd,
                        input logic [1:0] eerr, input int lat, input bit expect_resp);
      int n;
      exp_t e;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      op_id++;
      if (!req_ready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL accept_op%0d: req_ready stayed 0, required 1", op_id);
      end else if (expect_resp) begin
         e.rdata = erd;
         e.err   = eerr;
         e.lat   = lat;
         e.acc   = cyc + 1;
         e.id    = op_id;
         sb_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      req_valid = 1'b0;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks = checks + 1;
      if (sb_q.size() != 0 || busy) begin
         errors = errors + 1;
         $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
      end
      @(negedge clk);
   endtask

   int we_before;

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = '0;
      ram[8]  = 32'h11223344;
      ram[12] = 32'h80FF7F01;
      ram[16] = 32'h55667788;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = '0;
      req_addr = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);

      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {30'd0, resp_err}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_data_in", mem_data_in, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Word store then load.
      issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 2, 1'b1);
      wait_idle();
      check("sw_we_cycles", 32'(we_cycles), 32'd1);
      check("sw_we_addr", last_we_addr, 32'h10);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, 1'b1);
      check("ld_busy_c1", {31'd0, busy}, 32'd1);
      wait_idle();

      // Sub-word stores via read-modify-write.
      issue(1'b1, 3'd0, 32'h22, 32'h000000AB, 32'h0, 2'b00, 3, 1'b1);
      issue(1'b1, 3'd1, 32'h20, 32'h0000CAFE, 32'h0, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd2, 32'h20, 32'h0, 32'h11ABCAFE, 2'b00, 3, 1'b1);
      wait_idle();
      check("rmw_we_cycles", 32'(we_cycles), 32'd3);
      check("rmw_ram_word", ram[8], 32'h11ABCAFE);

      // Lane selection and extension.
      issue(1'b0, 3'd0, 32'h33, 32'h0, 32'hFFFFFF80, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd4, 32'h33, 32'h0, 32'h00000080, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd0, 32'h30, 32'h0, 32'h00000001, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd1, 32'h32, 32'h0, 32'hFFFF80FF, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd5, 32'h32, 32'h0, 32'h000080FF, 2'b00, 3, 1'b1);
      wait_idle();

      // Error responses: one cycle, no memory activity.
      we_before = we_cycles;
      issue(1'b0, 3'd2, 32'h31, 32'h0, 32'h0, 2'b01, 1, 1'b1);
      check("err_busy_c1", {31'd0, busy}, 32'd0);
      issue(1'b1, 3'd1, 32'h23, 32'hFFFF, 32'h0, 2'b01, 1, 1'b1);
      issue(1'b0, 3'd2, 32'h800, 32'h0, 32'h0, 2'b10, 1, 1'b1);
      issue(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 2'b11, 1, 1'b1);
      issue(1'b1, 3'd3, 32'h801, 32'hFF, 32'h0, 2'b11, 1, 1'b1);
      wait_idle();
      check("err_no_write", 32'(we_cycles), 32'(we_before));
      check("err_ram_20", ram[8], 32'h11ABCAFE);
      check("err_ram_30", ram[12], 32'h80FF7F01);

      // Back-to-back with req_valid held high.
      issue(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, 1'b1);
      issue(1'b1, 3'd2, 32'h14, 32'h12345678, 32'h0, 2'b00, 2, 1'b1);
      issue(1'b0, 3'd4, 32'h14, 32'h0, 32'h00000078, 2'b00, 3, 1'b1);
      issue(1'b0, 3'd7, 32'h14, 32'h0, 32'h0, 2'b11, 1, 1'b1);
      issue(1'b0, 3'd2, 32'h14, 32'h0, 32'h12345678, 2'b00, 3, 1'b1);
      wait_idle();
      check("b2b_we_cycles", 32'(we_cycles), 32'd4);

      // Reset in the read phase of a byte store drops it silently.
      issue(1'b1, 3'd0, 32'h40, 32'h99, 32'h0, 2'b00, 3, 1'b0);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      check("midrst_mem_address", mem_address, 32'd0);
      check("midrst_resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 3'd2, 32'h40, 32'h0, 32'h55667788, 2'b00, 3, 1'b1);
      wait_idle();
      check("midrst_ram_40", ram[16], 32'h55667788);
      check("midrst_we_cycles", 32'(we_cycles), 32'd4);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
